// File: rtl/interval_meter.sv
// Measures the number of prescaled ticks between a start and a stop event and
// presents the count on a valid/ready output, held until the consumer accepts it.
module interval_meter #(
    parameter int CLK_PERIOD_ns  = 20,
    parameter int TICK_PERIOD_ns = 1_000_000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic                   i_result_ready,
    output logic [COUNT_WIDTH-1:0] o_result,
    output logic                   o_result_valid,
    output logic                   o_overflow,
    output logic                   o_busy
);

    localparam int PRESCALE_RAW = TICK_PERIOD_ns / CLK_PERIOD_ns;
    localparam int PRESCALE     = (PRESCALE_RAW < 1) ? 1 : PRESCALE_RAW;
    localparam int PW           = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]          PS_LAST = PW'(PRESCALE - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEAS,
        S_HOLD
    } state_t;

    state_t                 r_state;
    logic [PW-1:0]          r_presc;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_result;
    logic                   r_overflow;
    logic                   r_valid;
    logic                   r_busy;

    logic                   w_tick;
    logic                   w_sat;
    logic [PW-1:0]          w_presc_nxt;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic                   w_ovf_nxt;

    // Tick-updated values for the current edge; a stop on this edge latches
    // these, so the stop edge itself still counts.
    always_comb begin
        w_tick      = (r_presc == PS_LAST);
        w_sat       = (r_count == CNT_MAX);
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        w_count_nxt = (w_tick && !w_sat) ? r_count + COUNT_WIDTH'(1) : r_count;
        w_ovf_nxt   = r_overflow | (w_tick & w_sat);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_count    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_MEAS;
                        r_presc    <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_MEAS: begin
                    if (i_stop) begin
                        r_state    <= S_HOLD;
                        r_presc    <= w_presc_nxt;
                        r_count    <= w_count_nxt;
                        r_result   <= w_count_nxt;
                        r_overflow <= w_ovf_nxt;
                        r_busy     <= 1'b0;
                        r_valid    <= 1'b1;
                    end else if (i_start) begin
                        r_presc    <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else begin
                        r_presc    <= w_presc_nxt;
                        r_count    <= w_count_nxt;
                        r_overflow <= w_ovf_nxt;
                    end
                end
                S_HOLD: begin
                    // Accept plus start goes straight back to measuring.
                    if (i_result_ready) begin
                        r_valid <= 1'b0;
                        if (i_start) begin
                            r_state    <= S_MEAS;
                            r_presc    <= '0;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_valid;
    assign o_overflow     = r_overflow;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_interval_meter.sv
// Scoreboard bench: two instances (prescale 4 / 16-bit, prescale 1 / 4-bit) share
// stimulus; expected results are queued per instance and checked on result_valid.
module tb_interval_meter;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_result_ready = 1'b1;

    logic [15:0] res_a;
    logic        val_a, ovf_a, busy_a;
    logic [3:0]  res_b;
    logic        val_b, ovf_b, busy_b;

    typedef struct {
        int res;
        int ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic prev_va = 1'b0;
    logic prev_vb = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    interval_meter #(.CLK_PERIOD_ns(20), .TICK_PERIOD_ns(80), .COUNT_WIDTH(16)) u_a (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
        .i_stop(i_stop), .i_result_ready(i_result_ready),
        .o_result(res_a), .o_result_valid(val_a), .o_overflow(ovf_a), .o_busy(busy_a)
    );

    interval_meter #(.CLK_PERIOD_ns(20), .TICK_PERIOD_ns(20), .COUNT_WIDTH(4)) u_b (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_start(i_start),
        .i_stop(i_stop), .i_result_ready(i_result_ready),
        .o_result(res_b), .o_result_valid(val_b), .o_overflow(ovf_b), .o_busy(busy_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare each freshly presented result against the queue head.
    always @(negedge clk) begin
        if (val_a && !prev_va) begin
            if (qa.size() == 0) check("a_unexpected_result", 1, 0);
            else begin
                ea = qa.pop_front();
                check("a_result", int'(res_a), ea.res);
                check("a_overflow", int'(ovf_a), ea.ovf);
            end
        end
        if (val_b && !prev_vb) begin
            if (qb.size() == 0) check("b_unexpected_result", 1, 0);
            else begin
                eb = qb.pop_front();
                check("b_result", int'(res_b), eb.res);
                check("b_overflow", int'(ovf_b), eb.ovf);
            end
        end
        prev_va <= val_a;
        prev_vb <= val_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int oa, input int b, input int ob);
        qa.push_back('{a, oa});
        qb.push_back('{b, ob});
    endtask

    // Start edge, n-1 plain edges, then the stop edge: N = n.
    task automatic meas(input int n, input int a, input int oa, input int b, input int ob);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_after_start", int'(busy_a), 1);
        repeat (n - 1) tick();
        push(a, oa, b, ob);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_res_a"}, int'(res_a), 0);
        check({tag, "_res_b"}, int'(res_b), 0);
        check({tag, "_valid"}, int'(val_a) + int'(val_b), 0);
        check({tag, "_busy"}, int'(busy_a) + int'(busy_b), 0);
        check({tag, "_ovf"}, int'(ovf_a) + int'(ovf_b), 0);
    endtask

    initial begin
        repeat (2) tick();
        i_reset = 1'b0;
        check_reset_state("reset");

        // Basic: N=10 -> 10/4=2 and 10 (B)
        meas(10, 2, 0, 10, 0);
        check("basic_valid", int'(val_a), 1);
        tick();
        check("basic_valid_drop", int'(val_a), 0);

        // Enable gating: 5 of 13 edges disabled -> N=8
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            i_enable = (k == 2 || k == 4 || k == 6 || k == 8 || k == 10) ? 1'b0 : 1'b1;
            if (k == 13) begin
                push(2, 0, 8, 0);
                i_stop = 1'b1;
            end
            tick();
            if (k == 10) begin
                check("gate_hold_busy", int'(busy_a), 1);
                check("gate_hold_valid", int'(val_a), 0);
            end
        end
        i_stop = 1'b0;
        i_enable = 1'b1;
        tick();

        // Saturation on B, then a short clean measurement
        meas(20, 5, 0, 15, 1);
        tick();
        meas(3, 0, 0, 3, 0);
        tick();

        // start+stop in IDLE starts; start+stop in MEASURING stops (N=6)
        i_start = 1'b1;
        i_stop = 1'b1;
        tick();
        check("idle_both_busy", int'(busy_a), 1);
        check("idle_both_valid", int'(val_a), 0);
        i_start = 1'b0;
        i_stop = 1'b0;
        repeat (5) tick();
        push(1, 0, 6, 0);
        i_start = 1'b1;
        i_stop = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop = 1'b0;
        check("meas_both_valid", int'(val_a), 1);
        tick();

        // Restart after 7 edges, then N=5 from the restart edge
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (7) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        push(1, 0, 5, 0);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        tick();

        // Back-pressure: result held 7 cycles, start ignored
        i_result_ready = 1'b0;
        meas(9, 2, 0, 9, 0);
        for (int c = 0; c < 7; c++) begin
            i_start = (c % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check("bp_res_a", int'(res_a), 2);
            check("bp_res_b", int'(res_b), 9);
            check("bp_valid", int'(val_a), 1);
            check("bp_busy", int'(busy_a), 0);
        end
        // Accept together with start: straight back to measuring, N=4
        i_result_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("b2b_busy", int'(busy_a), 1);
        check("b2b_valid", int'(val_a), 0);
        repeat (3) tick();
        push(1, 0, 4, 0);
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        tick();

        // Reset while measuring, then a lone stop is ignored
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (5) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_state("rst_meas");
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("rst_stop_valid", int'(val_a), 0);
        check("rst_stop_busy", int'(busy_a), 0);

        // Reset while holding a result
        i_result_ready = 1'b0;
        meas(8, 2, 0, 8, 0);
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_reset_state("rst_hold");
        i_result_ready = 1'b1;
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        check("rst_hold_stop_valid", int'(val_a), 0);

        repeat (3) tick();
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule
